// File: rtl/l2_pkg.sv
// Shared types and constants for the L2 victim allocation controller.
package l2_pkg;

  localparam int unsigned WAYS           = 16;
  localparam int unsigned WAY_W          = 4;
  localparam int unsigned STAMP_LAT_DFLT = 3;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StPick,
    StWb,
    StFill,
    StDone
  } state_e;

endpackage

// File: rtl/l2_first_invalid.sv
// Lowest-index invalid way finder: 16-to-4 priority encoder on zero bits.
module l2_first_invalid
  import l2_pkg::*;
(
  input  logic [WAYS-1:0]  i_valid,
  output logic [WAY_W-1:0] o_idx,
  output logic             o_any_invalid
);

  // Scan high to low so the lowest invalid way wins.
  always_comb begin
    o_idx         = '0;
    o_any_invalid = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!i_valid[i]) begin
        o_idx         = WAY_W'(i);
        o_any_invalid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_victim_alloc.sv
// L2 replacement controller: hit stamping, victim pick, writeback and fill sequencing.
module l2_victim_alloc
  import l2_pkg::*;
#(
  parameter int unsigned STAMP_LAT = STAMP_LAT_DFLT
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_hit,
  input  logic [WAY_W-1:0] i_req_hit_way,
  input  logic [WAYS-1:0]  i_way_valid,
  input  logic [WAYS-1:0]  i_way_dirty,
  output logic             o_stamp_en,
  output logic [WAY_W-1:0] o_stamp_access,
  input  logic [WAY_W-1:0] i_oldest_way,
  output logic             o_wb_req,
  output logic [WAY_W-1:0] o_wb_way,
  input  logic             i_wb_ack,
  output logic             o_fill_req,
  output logic [WAY_W-1:0] o_fill_way,
  input  logic             i_fill_ack,
  output logic             o_rsp_done,
  output logic [WAY_W-1:0] o_rsp_way
);

  localparam int unsigned CNT_W = $clog2(STAMP_LAT + 1);

  state_e             r_state, w_state_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d;
  logic [WAY_W-1:0]   r_victim, w_victim_d;
  logic               r_req_ready;
  logic               r_stamp_en, w_stamp_en_d;
  logic [WAY_W-1:0]   r_stamp_access, w_stamp_access_d;
  logic               r_wb_req, w_wb_req_d;
  logic [WAY_W-1:0]   r_wb_way, w_wb_way_d;
  logic               r_fill_req, w_fill_req_d;
  logic [WAY_W-1:0]   r_fill_way, w_fill_way_d;
  logic               r_rsp_done, w_rsp_done_d;
  logic [WAY_W-1:0]   r_rsp_way, w_rsp_way_d;

  logic [WAY_W-1:0]   w_inv_idx;
  logic               w_any_invalid;
  logic [WAY_W-1:0]   w_pick_way;
  logic               w_accept;

  l2_first_invalid u_first_invalid (
    .i_valid       (i_way_valid),
    .o_idx         (w_inv_idx),
    .o_any_invalid (w_any_invalid)
  );

  assign w_accept   = i_req_valid & r_req_ready;
  assign w_pick_way = w_any_invalid ? w_inv_idx : i_oldest_way;

  // Counter tracks how long the tracker's oldest-way output may still be stale.
  always_comb begin
    if (r_stamp_en) begin
      w_cnt_d = CNT_W'(STAMP_LAT);
    end else if (r_cnt != '0) begin
      w_cnt_d = r_cnt - 1'b1;
    end else begin
      w_cnt_d = '0;
    end
  end

  always_comb begin
    w_state_d        = r_state;
    w_victim_d       = r_victim;
    w_stamp_en_d     = 1'b0;
    w_stamp_access_d = '0;
    w_wb_req_d       = 1'b0;
    w_wb_way_d       = '0;
    w_fill_req_d     = 1'b0;
    w_fill_way_d     = '0;
    w_rsp_done_d     = 1'b0;
    w_rsp_way_d      = '0;
    unique case (r_state)
      StIdle: begin
        if (w_accept && i_req_hit) begin
          w_stamp_en_d     = 1'b1;
          w_stamp_access_d = i_req_hit_way;
          w_rsp_done_d     = 1'b1;
          w_rsp_way_d      = i_req_hit_way;
        end else if (w_accept) begin
          w_state_d = ((r_cnt != '0) || r_stamp_en) ? StSettle : StPick;
        end
      end
      StSettle: begin
        if (w_cnt_d == '0) w_state_d = StPick;
      end
      StPick: begin
        w_victim_d = w_pick_way;
        if (i_way_valid[w_pick_way] && i_way_dirty[w_pick_way]) begin
          w_state_d  = StWb;
          w_wb_req_d = 1'b1;
          w_wb_way_d = w_pick_way;
        end else begin
          w_state_d    = StFill;
          w_fill_req_d = 1'b1;
          w_fill_way_d = w_pick_way;
        end
      end
      StWb: begin
        if (i_wb_ack) begin
          w_state_d    = StFill;
          w_fill_req_d = 1'b1;
          w_fill_way_d = r_victim;
        end else begin
          w_wb_req_d = 1'b1;
          w_wb_way_d = r_victim;
        end
      end
      StFill: begin
        if (i_fill_ack) begin
          w_state_d        = StDone;
          w_stamp_en_d     = 1'b1;
          w_stamp_access_d = r_victim;
          w_rsp_done_d     = 1'b1;
          w_rsp_way_d      = r_victim;
        end else begin
          w_fill_req_d = 1'b1;
          w_fill_way_d = r_victim;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_victim       <= '0;
      r_req_ready    <= 1'b0;
      r_stamp_en     <= 1'b0;
      r_stamp_access <= '0;
      r_wb_req       <= 1'b0;
      r_wb_way       <= '0;
      r_fill_req     <= 1'b0;
      r_fill_way     <= '0;
      r_rsp_done     <= 1'b0;
      r_rsp_way      <= '0;
    end else begin
      r_state        <= w_state_d;
      r_cnt          <= w_cnt_d;
      r_victim       <= w_victim_d;
      r_req_ready    <= (w_state_d == StIdle);
      r_stamp_en     <= w_stamp_en_d;
      r_stamp_access <= w_stamp_access_d;
      r_wb_req       <= w_wb_req_d;
      r_wb_way       <= w_wb_way_d;
      r_fill_req     <= w_fill_req_d;
      r_fill_way     <= w_fill_way_d;
      r_rsp_done     <= w_rsp_done_d;
      r_rsp_way      <= w_rsp_way_d;
    end
  end

  assign o_req_ready    = r_req_ready;
  assign o_stamp_en     = r_stamp_en;
  assign o_stamp_access = r_stamp_access;
  assign o_wb_req       = r_wb_req;
  assign o_wb_way       = r_wb_way;
  assign o_fill_req     = r_fill_req;
  assign o_fill_way     = r_fill_way;
  assign o_rsp_done     = r_rsp_done;
  assign o_rsp_way      = r_rsp_way;

endmodule

// File: tb/tb_l2_victim_alloc.sv
// Self-checking bench for l2_victim_alloc: vector table, corner sequences, random transactions.
module tb_l2_victim_alloc;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_hit;
  logic [3:0]  req_hit_way;
  logic [15:0] way_valid, way_dirty;
  logic        stamp_en;
  logic [3:0]  stamp_access, oldest_way;
  logic        wb_req, wb_ack, fill_req, fill_ack, rsp_done;
  logic [3:0]  wb_way, fill_way, rsp_way;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_stamp = -100;

  l2_victim_alloc u_dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_hit      (req_hit),
    .i_req_hit_way  (req_hit_way),
    .i_way_valid    (way_valid),
    .i_way_dirty    (way_dirty),
    .o_stamp_en     (stamp_en),
    .o_stamp_access (stamp_access),
    .i_oldest_way   (oldest_way),
    .o_wb_req       (wb_req),
    .o_wb_way       (wb_way),
    .i_wb_ack       (wb_ack),
    .o_fill_req     (fill_req),
    .o_fill_way     (fill_way),
    .i_fill_ack     (fill_ack),
    .o_rsp_done     (rsp_done),
    .o_rsp_way      (rsp_way)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic        hit;
    logic [3:0]  way;
    logic [15:0] valid;
    logic [15:0] dirty;
    logic [3:0]  oldest;
    int          wb_lat;
    int          fill_lat;
    logic [3:0]  exp_way;
    logic        exp_wb;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Victim from the replacement rules: lowest invalid way, else the tracker's oldest way.
  function automatic logic [3:0] model_victim(input logic [15:0] v, input logic [3:0] old);
    logic [15:0] lowest_zero;
    logic [3:0]  idx;
    lowest_zero = ~v & (v + 16'd1);
    idx = old;
    for (int i = 0; i < 16; i++) if (lowest_zero[i]) idx = 4'(i);
    return idx;
  endfunction

  task automatic do_hit(input logic [3:0] w);
    chk("hit_ready", 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_hit     = 1'b1;
    req_hit_way = w;
    tick();
    req_valid  = 1'b0;
    req_hit    = 1'b0;
    last_stamp = cyc;
    chk("hit_rsp", 32'({stamp_en, stamp_access, rsp_done, rsp_way, req_ready}),
        32'({1'b1, w, 1'b1, w, 1'b1}));
  endtask

  task automatic do_miss(input logic [15:0] v, input logic [15:0] d, input logic [3:0] old,
                         input int wb_lat, input int fill_lat,
                         input logic [3:0] exp_way, input logic exp_wb);
    int         e0, delta, pick_edge;
    logic [3:0] decoy;
    logic       early;
    chk("miss_ready", 32'(req_ready), 32'd1);
    decoy       = old ^ 4'h8;
    req_valid   = 1'b1;
    req_hit     = 1'b0;
    req_hit_way = 4'($urandom_range(15, 0));
    way_valid   = v;
    way_dirty   = d;
    oldest_way  = decoy;
    tick();
    req_valid = 1'b0;
    e0        = cyc;
    // Oldest-way output is trusted only LAT+1 edges after the last stamp edge.
    delta = e0 - last_stamp;
    if (delta <= LAT)          pick_edge = last_stamp + LAT + 1;
    else if (delta == LAT + 1) pick_edge = e0 + 1;
    else                       pick_edge = e0;
    early = 1'b0;
    while (cyc < pick_edge + 1) begin
      oldest_way = (cyc >= pick_edge) ? old : decoy;
      if (wb_req || fill_req || req_ready || rsp_done) early = 1'b1;
      tick();
    end
    chk("miss_quiet_before_pick", 32'(early), 32'd0);
    if (exp_wb) begin
      for (int i = 1; i <= wb_lat; i++) begin
        chk("wb_phase", 32'({wb_req, wb_way, fill_req, req_ready}),
            32'({1'b1, exp_way, 1'b0, 1'b0}));
        if (i == wb_lat) wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
      end
    end
    for (int i = 1; i <= fill_lat; i++) begin
      chk("fill_phase", 32'({fill_req, fill_way, wb_req, req_ready}),
          32'({1'b1, exp_way, 1'b0, 1'b0}));
      if (i == fill_lat) fill_ack = 1'b1;
      tick();
      fill_ack = 1'b0;
    end
    last_stamp = cyc;
    chk("done_rsp", 32'({stamp_en, stamp_access, rsp_done, rsp_way, fill_req, req_ready}),
        32'({1'b1, exp_way, 1'b1, exp_way, 1'b0, 1'b0}));
    tick();
    chk("back_to_idle", 32'({req_ready, rsp_done, stamp_en}), 32'({1'b1, 1'b0, 1'b0}));
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      wb_ack   = 1'($urandom_range(1, 0));
      fill_ack = 1'($urandom_range(1, 0));
      tick();
      chk("idle", 32'({req_ready, rsp_done, wb_req, fill_req}), 32'({1'b1, 3'b000}));
    end
    wb_ack   = 1'b0;
    fill_ack = 1'b0;
  endtask

  initial begin
    logic [15:0] rv, rd;
    logic [3:0]  ro, rvic;
    vecs[0]  = '{1'b1, 4'd5,  16'h0000, 16'h0000, 4'd0,  0, 0, 4'd5,  1'b0};
    vecs[1]  = '{1'b0, 4'd0,  16'hFFF7, 16'hFFFF, 4'd0,  0, 3, 4'd3,  1'b0};
    vecs[2]  = '{1'b0, 4'd0,  16'hFFFF, 16'h0200, 4'd9,  4, 2, 4'd9,  1'b1};
    vecs[3]  = '{1'b1, 4'd2,  16'h0000, 16'h0000, 4'd0,  0, 0, 4'd2,  1'b0};
    vecs[4]  = '{1'b0, 4'd0,  16'hFFFF, 16'h0000, 4'd12, 0, 1, 4'd12, 1'b0};
    vecs[5]  = '{1'b0, 4'd0,  16'hFFFF, 16'hFFFF, 4'd0,  1, 1, 4'd0,  1'b1};
    vecs[6]  = '{1'b0, 4'd0,  16'h7FFF, 16'h8000, 4'd4,  0, 2, 4'd15, 1'b0};
    vecs[7]  = '{1'b0, 4'd0,  16'h0000, 16'hFFFF, 4'd6,  0, 1, 4'd0,  1'b0};
    vecs[8]  = '{1'b1, 4'd15, 16'h0000, 16'h0000, 4'd0,  0, 0, 4'd15, 1'b0};
    vecs[9]  = '{1'b1, 4'd0,  16'h0000, 16'h0000, 4'd0,  0, 0, 4'd0,  1'b0};
    vecs[10] = '{1'b0, 4'd0,  16'hFFFE, 16'hFFFF, 4'd7,  0, 2, 4'd0,  1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_hit = 1'b0; req_hit_way = '0;
    way_valid = '0; way_dirty = '0; oldest_way = '0; wb_ack = 1'b0; fill_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({req_ready, stamp_en, wb_req, fill_req, rsp_done,
                             stamp_access, wb_way, fill_way, rsp_way}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", 32'({req_ready, rsp_done}), 32'({1'b1, 1'b0}));

    // Vectors back-to-back: exercises hit->miss settle and hit->hit streaming.
    for (int k = 0; k < 11; k++) begin
      if (vecs[k].hit) do_hit(vecs[k].way);
      else do_miss(vecs[k].valid, vecs[k].dirty, vecs[k].oldest, vecs[k].wb_lat,
                   vecs[k].fill_lat, vecs[k].exp_way, vecs[k].exp_wb);
    end

    // Reset in the middle of a fill aborts it with no response.
    idle_gap(6);
    req_valid = 1'b1; req_hit = 1'b0; way_valid = 16'hFFFE; way_dirty = '0;
    tick();
    req_valid = 1'b0;
    tick();
    chk("pre_abort_fill", 32'({fill_req, fill_way}), 32'({1'b1, 4'd0}));
    tick();
    #2 rst_n = 1'b0;
    #1 chk("abort_async", 32'({fill_req, wb_req, req_ready, rsp_done, stamp_en}), 32'd0);
    @(negedge clk);
    fill_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    last_stamp = -100;
    tick();
    fill_ack = 1'b0;
    chk("after_abort", 32'({req_ready, rsp_done, fill_req, stamp_en}), 32'({1'b1, 3'b000}));
    do_miss(16'hFFFF, 16'h0010, 4'd4, 2, 1, 4'd4, 1'b1);

    // Random transactions against the rule model.
    for (int n = 0; n < 60; n++) begin
      idle_gap(int'($urandom_range(5, 0)));
      if ($urandom_range(1, 0) == 1) begin
        do_hit(4'($urandom_range(15, 0)));
      end else begin
        rv = ($urandom_range(1, 0) == 1) ? 16'hFFFF : 16'($urandom);
        rd = 16'($urandom);
        ro = 4'($urandom_range(15, 0));
        rvic = model_victim(rv, ro);
        do_miss(rv, rd, ro, int'($urandom_range(4, 1)), int'($urandom_range(4, 1)),
                rvic, rv[rvic] & rd[rvic]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
